// File: rtl/rf_pkg.sv
// Shared types and defaults for the range frame sequencer: replay/fill FSM states
// and the default sample width / FIFO depth.
package rf_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int PTR_W     = $clog2(DEPTH_DEF);

    typedef enum logic [2:0] {IDLE, GO, RUN, FIN, GAP} replay_state_t;
    typedef enum logic {FILL, DROP} fill_state_t;

endpackage

// File: rtl/range_frame_sequencer_if.sv
// Bundle of the sample stream, the range finder link, status pulses and FSM debug taps.
interface range_frame_sequencer_if
    import rf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    // Stream handshake: a sample moves on a cycle where in_valid and in_ready are both 1.
    // in_valid/in_last/in_data must hold steady until that cycle; in_ready never depends on in_valid.
    logic             in_valid;
    logic             in_last;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;

    logic [WIDTH-1:0] rf_data;
    logic             rf_go;
    logic             rf_finish;
    logic [WIDTH-1:0] rf_range;
    logic             rf_error;

    logic [WIDTH-1:0] range_out;
    logic             range_valid;
    logic             frame_err;
    logic             busy;

    replay_state_t          dbg_replay_state;
    fill_state_t            dbg_fill_state;
    logic [$clog2(DEPTH):0] dbg_count;

    modport master (
        output in_valid, in_last, in_data, rf_range, rf_error,
        input  in_ready, rf_data, rf_go, rf_finish, range_out, range_valid, frame_err, busy,
        input  dbg_replay_state, dbg_fill_state, dbg_count
    );

    modport slave (
        input  in_valid, in_last, in_data, rf_range, rf_error,
        output in_ready, rf_data, rf_go, rf_finish, range_out, range_valid, frame_err, busy,
        output dbg_replay_state, dbg_fill_state, dbg_count
    );

endinterface

// File: rtl/range_frame_sequencer_fifo.sv
// Synchronous FIFO with a one-ahead peek of the last flag and a write-pointer rewind
// used to discard an oversized partial frame.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   rewind,
    input  logic [$clog2(DEPTH):0] rewind_ptr,
    output logic [W-1:0]           head,
    output logic                   peek_last,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] wr_ptr
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr;
    logic [AW:0]   rd;
    logic [AW:0]   rd_next;
    logic          empty;
    logic          do_pop;
    logic          do_push;

    assign empty   = (wr == rd);
    assign full    = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign count   = wr - rd;
    assign wr_ptr  = wr;
    assign rd_next = rd + 1'b1;

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop) & ~rewind;

    assign head      = mem[rd[AW-1:0]];
    assign peek_last = mem[rd_next[AW-1:0]][W-1];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (rewind) begin
                wr <= rewind_ptr;
            end else if (do_push) begin
                wr <= wr + 1'b1;
            end
            if (do_pop) begin
                rd <= rd_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/range_frame_sequencer.sv
// Buffers whole sample frames and replays each one gap-free to the range finder,
// capturing the range it reports in the finish cycle.
module range_frame_sequencer
    import rf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input logic                    clock,
    input logic                    reset_n,
    range_frame_sequencer_if.slave bus
);
    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] OPEN_MAX = (AW+1)'(DEPTH - 1);

    fill_state_t   fill_state, fill_next;
    replay_state_t rs, rs_next;
    logic          flushing, flushing_next;
    logic [AW:0]   open_cnt, open_cnt_next;
    logic [AW:0]   frame_start;
    logic [AW:0]   pending;
    logic          alive;

    logic [WIDTH:0] head;
    logic           peek_last;
    logic           full;
    logic [AW:0]    count;
    logic [AW:0]    wr_ptr;
    logic           push, pop, rewind;

    logic             ready;
    logic             inc_pend, dec_pend, cap_range;
    logic             fill_err, replay_err;
    logic             go, finish;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] range_q;
    logic             range_valid_q, frame_err_q;

    sync_fifo #(.W(WIDTH + 1), .DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_data  ({bus.in_last, bus.in_data}),
        .pop        (pop),
        .rewind     (rewind),
        .rewind_ptr (frame_start),
        .head       (head),
        .peek_last  (peek_last),
        .full       (full),
        .count      (count),
        .wr_ptr     (wr_ptr)
    );

    // Input side: store frames, reject single-sample frames, drop frames longer than DEPTH.
    always_comb begin
        fill_next     = fill_state;
        open_cnt_next = open_cnt;
        push          = 1'b0;
        rewind        = 1'b0;
        inc_pend      = 1'b0;
        fill_err      = 1'b0;
        ready         = 1'b0;
        case (fill_state)
            FILL: begin
                ready = alive & ~full;
                if (bus.in_valid && ready) begin
                    if (bus.in_last) begin
                        if (open_cnt == '0) begin
                            fill_err = 1'b1;
                        end else begin
                            push          = 1'b1;
                            inc_pend      = 1'b1;
                            open_cnt_next = '0;
                        end
                    end else if (open_cnt == OPEN_MAX) begin
                        rewind        = 1'b1;
                        open_cnt_next = '0;
                        fill_next     = DROP;
                    end else begin
                        push          = 1'b1;
                        open_cnt_next = open_cnt + 1'b1;
                    end
                end
            end
            DROP: begin
                ready = alive;
                if (bus.in_valid && bus.in_last) begin
                    fill_err  = 1'b1;
                    fill_next = FILL;
                end
            end
            default: fill_next = FILL;
        endcase
    end

    // Replay side: one pop per cycle from GO through FIN so the range finder never sees a bubble.
    always_comb begin
        rs_next       = rs;
        flushing_next = flushing;
        pop           = 1'b0;
        go            = 1'b0;
        finish        = 1'b0;
        data          = '0;
        dec_pend      = 1'b0;
        cap_range     = 1'b0;
        replay_err    = 1'b0;
        case (rs)
            IDLE: begin
                if (pending != '0) rs_next = GO;
            end
            GO, RUN: begin
                pop  = 1'b1;
                go   = 1'b1;
                data = head[WIDTH-1:0];
                if (bus.rf_error) begin
                    rs_next       = GAP;
                    flushing_next = 1'b1;
                end else if (peek_last) begin
                    rs_next = FIN;
                end else begin
                    rs_next = RUN;
                end
            end
            FIN: begin
                pop      = 1'b1;
                finish   = 1'b1;
                data     = head[WIDTH-1:0];
                dec_pend = 1'b1;
                rs_next  = GAP;
                if (bus.rf_error) replay_err = 1'b1;
                else              cap_range  = 1'b1;
            end
            GAP: begin
                if (flushing) begin
                    pop = 1'b1;
                    if (head[WIDTH]) begin
                        flushing_next = 1'b0;
                        dec_pend      = 1'b1;
                        replay_err    = 1'b1;
                        rs_next       = IDLE;
                    end
                end else if (pending != '0) begin
                    rs_next = GO;
                end else begin
                    rs_next = IDLE;
                end
            end
            default: rs_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill_state    <= FILL;
            rs            <= IDLE;
            flushing      <= 1'b0;
            open_cnt      <= '0;
            frame_start   <= '0;
            pending       <= '0;
            alive         <= 1'b0;
            range_q       <= '0;
            range_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            fill_state    <= fill_next;
            rs            <= rs_next;
            flushing      <= flushing_next;
            open_cnt      <= open_cnt_next;
            alive         <= 1'b1;
            range_valid_q <= cap_range;
            frame_err_q   <= fill_err | replay_err;
            if (push && bus.in_last) begin
                frame_start <= wr_ptr + 1'b1;
            end
            if (inc_pend && !dec_pend) begin
                pending <= pending + 1'b1;
            end else if (dec_pend && !inc_pend) begin
                pending <= pending - 1'b1;
            end
            if (cap_range) begin
                range_q <= bus.rf_range;
            end
        end
    end

    assign bus.in_ready         = ready;
    assign bus.rf_data          = data;
    assign bus.rf_go            = go;
    assign bus.rf_finish        = finish;
    assign bus.range_out        = range_q;
    assign bus.range_valid      = range_valid_q;
    assign bus.frame_err        = frame_err_q;
    assign bus.busy             = (rs != IDLE);
    assign bus.dbg_replay_state = rs;
    assign bus.dbg_fill_state   = fill_state;
    assign bus.dbg_count        = count;

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Directed bench for range_frame_sequencer with a max-min range finder model and a
// trace scoreboard of everything driven toward the range finder.
module tb_range_frame_sequencer;
    import rf_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    range_frame_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    range_frame_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Range finder model: max-min over the go samples plus the finish sample.
    logic [WIDTH-1:0] m_lo, m_hi, lo_now, hi_now;
    logic             m_run;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_run <= 1'b0;
            m_lo  <= '0;
            m_hi  <= '0;
        end else if (bus.rf_go) begin
            if (!m_run) begin
                m_lo  <= bus.rf_data;
                m_hi  <= bus.rf_data;
                m_run <= 1'b1;
            end else begin
                if (bus.rf_data < m_lo) m_lo <= bus.rf_data;
                if (bus.rf_data > m_hi) m_hi <= bus.rf_data;
            end
        end else begin
            m_run <= 1'b0;
        end
    end

    assign lo_now       = (bus.rf_data < m_lo) ? bus.rf_data : m_lo;
    assign hi_now       = (bus.rf_data > m_hi) ? bus.rf_data : m_hi;
    assign bus.rf_range = bus.rf_finish ? (hi_now - lo_now) : '0;

    // Monitor samples exactly on the falling edge; the stimulus acts 1 time unit later.
    logic [WIDTH+1:0] tr_q[$];
    logic [WIDTH+1:0] exp_q[$];
    logic [WIDTH-1:0] rng_q[$];
    int               ferr_cnt = 0;
    int               total    = 0;
    int               bad      = 0;

    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.busy || bus.rf_go || bus.rf_finish)
                tr_q.push_back({bus.rf_go, bus.rf_finish, bus.rf_data});
            if (bus.range_valid) rng_q.push_back(bus.range_out);
            if (bus.frame_err) ferr_cnt++;
        end
    end

    function automatic logic [WIDTH+1:0] enc(input logic g, input logic f, input logic [WIDTH-1:0] d);
        return {g, f, d};
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_trace(input string tag);
        check({tag, "_len"}, tr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < tr_q.size(); i++)
            check($sformatf("%s_%0d", tag, i), 32'(tr_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_logs();
        tr_q.delete();
        exp_q.delete();
        rng_q.delete();
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && n < 64) begin
            tick();
            n++;
        end
        check("send_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_go(input string tag);
        int n = 0;
        while (!bus.rf_go && n < 32) begin
            tick();
            n++;
        end
        check(tag, 32'(bus.rf_go), 32'd1);
    endtask

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        bus.rf_error = 1'b0;

        // Reset state.
        #1;
        check("rst_go", 32'(bus.rf_go), 0);
        check("rst_finish", 32'(bus.rf_finish), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_ready", 32'(bus.in_ready), 0);
        check("rst_range", 32'(bus.range_out), 0);
        tick();
        reset_n = 1'b1;
        wait_cycles(2);
        check("post_rst_ready", 32'(bus.in_ready), 1);
        check("post_rst_count", 32'(bus.dbg_count), 0);
        check("post_rst_fill", 32'(bus.dbg_fill_state), 32'(FILL));

        // Frame {5,9,2,7}.
        clear_logs();
        base = ferr_cnt;
        send(8'd5, 1'b0);
        send(8'd9, 1'b0);
        send(8'd2, 1'b0);
        send(8'd7, 1'b1);
        wait_cycles(10);
        exp_q = '{enc(1, 0, 8'd5), enc(1, 0, 8'd9), enc(1, 0, 8'd2), enc(0, 1, 8'd7), enc(0, 0, 8'd0)};
        check_trace("t1_trace");
        check("t1_nrange", rng_q.size(), 1);
        if (rng_q.size() > 0) check("t1_range", 32'(rng_q[0]), 7);
        check("t1_ferr", ferr_cnt - base, 0);
        check("t1_busy", 32'(bus.busy), 0);

        // Back-to-back frames {3,3} and {1,200}.
        clear_logs();
        send(8'd3, 1'b0);
        send(8'd3, 1'b1);
        send(8'd1, 1'b0);
        send(8'd200, 1'b1);
        wait_cycles(12);
        exp_q = '{enc(1, 0, 8'd3), enc(0, 1, 8'd3), enc(0, 0, 8'd0),
                  enc(1, 0, 8'd1), enc(0, 1, 8'd200), enc(0, 0, 8'd0)};
        check_trace("t2_trace");
        check("t2_nrange", rng_q.size(), 2);
        if (rng_q.size() > 1) begin
            check("t2_range0", 32'(rng_q[0]), 0);
            check("t2_range1", 32'(rng_q[1]), 199);
        end

        // Single-sample frame.
        clear_logs();
        base = ferr_cnt;
        send(8'd42, 1'b1);
        wait_cycles(6);
        check("t3_ferr", ferr_cnt - base, 1);
        check("t3_trace_len", tr_q.size(), 0);
        check("t3_count", 32'(bus.dbg_count), 0);

        // 20-sample frame is dropped, then {10,20}.
        clear_logs();
        base = ferr_cnt;
        for (int i = 1; i <= 20; i++) begin
            send(8'(i), i == 20);
            if (i == 15) check("t4_fill15", 32'(bus.dbg_fill_state), 32'(FILL));
            if (i == 16) begin
                check("t4_drop16", 32'(bus.dbg_fill_state), 32'(DROP));
                check("t4_rewound", 32'(bus.dbg_count), 0);
            end
            if (i == 19) check("t4_ferr19", ferr_cnt - base, 0);
        end
        tick();
        check("t4_ferr20", ferr_cnt - base, 1);
        check("t4_fill_back", 32'(bus.dbg_fill_state), 32'(FILL));
        check("t4_trace_empty", tr_q.size(), 0);
        send(8'd10, 1'b0);
        send(8'd20, 1'b1);
        wait_cycles(8);
        exp_q = '{enc(1, 0, 8'd10), enc(0, 1, 8'd20), enc(0, 0, 8'd0)};
        check_trace("t4_trace");
        check("t4_nrange", rng_q.size(), 1);
        if (rng_q.size() > 0) check("t4_range", 32'(rng_q[0]), 10);

        // rf_error during RUN flushes the frame.
        clear_logs();
        base = ferr_cnt;
        send(8'd4, 1'b0);
        send(8'd8, 1'b0);
        send(8'd6, 1'b0);
        send(8'd1, 1'b1);
        wait_go("t5_go");
        tick();
        check("t5_run", 32'(bus.dbg_replay_state), 32'(RUN));
        bus.rf_error = 1'b1;
        tick();
        bus.rf_error = 1'b0;
        wait_cycles(6);
        exp_q = '{enc(1, 0, 8'd4), enc(1, 0, 8'd8), enc(0, 0, 8'd0), enc(0, 0, 8'd0)};
        check_trace("t5_trace");
        check("t5_nrange", rng_q.size(), 0);
        check("t5_ferr", ferr_cnt - base, 1);
        check("t5_count", 32'(bus.dbg_count), 0);
        clear_logs();
        send(8'd7, 1'b0);
        send(8'd3, 1'b1);
        wait_cycles(8);
        exp_q = '{enc(1, 0, 8'd7), enc(0, 1, 8'd3), enc(0, 0, 8'd0)};
        check_trace("t5_next_trace");
        check("t5_next_nrange", rng_q.size(), 1);
        if (rng_q.size() > 0) check("t5_next_range", 32'(rng_q[0]), 4);

        // Reset in the middle of RUN.
        for (int i = 1; i <= 6; i++) send(8'(i * 3), i == 6);
        wait_go("t6_go");
        tick();
        reset_n = 1'b0;
        #1;
        check("t6_go", 32'(bus.rf_go), 0);
        check("t6_finish", 32'(bus.rf_finish), 0);
        check("t6_data", 32'(bus.rf_data), 0);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_range", 32'(bus.range_out), 0);
        check("t6_rvalid", 32'(bus.range_valid), 0);
        check("t6_ferr", 32'(bus.frame_err), 0);
        tick();
        reset_n = 1'b1;
        wait_cycles(2);
        clear_logs();
        check("t6_ready", 32'(bus.in_ready), 1);
        check("t6_count", 32'(bus.dbg_count), 0);
        check("t6_idle", 32'(bus.dbg_replay_state), 32'(IDLE));
        wait_cycles(10);
        check("t6_no_replay", tr_q.size(), 0);
        check("t6_no_range", rng_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
